// File: rtl/active_list_if.sv
// Bundles rename-side allocation, completion, flush and retirement signals of the active list.
interface active_list_if #(
    parameter int DEPTH  = 32,
    parameter int PREG_W = 6,
    parameter int LREG_W = 5,
    parameter int TAG_W  = $clog2(DEPTH)
);
    logic              alloc_valid;
    logic              alloc_uses_rw;
    logic [LREG_W-1:0] alloc_lreg;
    logic [PREG_W-1:0] alloc_new_preg;
    logic [PREG_W-1:0] alloc_prev_preg;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              complete_valid;
    logic [TAG_W-1:0]  complete_tag;
    logic              flush;
    logic              commit_valid;
    logic [LREG_W-1:0] commit_lreg;
    logic [PREG_W-1:0] commit_new_preg;
    logic              free_valid;
    logic [PREG_W-1:0] free_preg;
    logic [TAG_W:0]    count;
    logic              empty;
    logic              full;

    modport master (
        output alloc_valid, alloc_uses_rw, alloc_lreg, alloc_new_preg, alloc_prev_preg,
        output complete_valid, complete_tag, flush,
        input  alloc_ready, alloc_tag, commit_valid, commit_lreg, commit_new_preg,
        input  free_valid, free_preg, count, empty, full
    );

    modport slave (
        input  alloc_valid, alloc_uses_rw, alloc_lreg, alloc_new_preg, alloc_prev_preg,
        input  complete_valid, complete_tag, flush,
        output alloc_ready, alloc_tag, commit_valid, commit_lreg, commit_new_preg,
        output free_valid, free_preg, count, empty, full
    );
endinterface

// File: rtl/active_list.sv
// In-order retirement buffer: allocate at tail, mark done by tag, retire one entry per cycle from head.
// Latency: complete in cycle N -> commit/free pulse registered in cycle N+2 at the earliest.
// Backpressure: alloc_ready drops when full (registered count); allocations presented while full are dropped.
module active_list #(
    parameter int DEPTH  = 32,
    parameter int PREG_W = 6,
    parameter int LREG_W = 5,
    parameter int TAG_W  = $clog2(DEPTH)
) (
    input logic         clk,
    input logic         rst_n,
    active_list_if.slave al
);
    typedef struct packed {
        logic              uses_rw;
        logic [LREG_W-1:0] lreg;
        logic [PREG_W-1:0] new_preg;
        logic [PREG_W-1:0] prev_preg;
    } entry_t;

    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;
    logic              commit_valid_q, commit_valid_d;
    logic [LREG_W-1:0] commit_lreg_q, commit_lreg_d;
    logic [PREG_W-1:0] commit_new_preg_q, commit_new_preg_d;
    logic              free_valid_q, free_valid_d;
    logic [PREG_W-1:0] free_preg_q, free_preg_d;
    entry_t            mem_q [DEPTH];

    logic   full, alloc_fire, commit_fire;
    entry_t head_entry;

    assign full        = (count_q == FULL_CNT);
    assign head_entry  = mem_q[head_q];
    assign alloc_fire  = !al.flush && al.alloc_valid && !full;
    assign commit_fire = !al.flush && valid_q[head_q] && done_q[head_q];

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        // An entry allocated this cycle is not yet valid, so a same-cycle completion to it is lost.
        if (al.complete_valid && valid_q[al.complete_tag]) done_d[al.complete_tag] = 1'b1;
        if (commit_fire) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
        end
        if (alloc_fire) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
        end
        head_d  = head_q + TAG_W'(commit_fire);
        tail_d  = tail_q + TAG_W'(alloc_fire);
        count_d = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_fire);
        if (al.flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end

        commit_valid_d    = commit_fire;
        commit_lreg_d     = commit_fire ? head_entry.lreg     : commit_lreg_q;
        commit_new_preg_d = commit_fire ? head_entry.new_preg : commit_new_preg_q;
        free_valid_d      = commit_fire && head_entry.uses_rw;
        free_preg_d       = commit_fire ? head_entry.prev_preg : free_preg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q           <= '0;
            done_q            <= '0;
            head_q            <= '0;
            tail_q            <= '0;
            count_q           <= '0;
            commit_valid_q    <= 1'b0;
            commit_lreg_q     <= '0;
            commit_new_preg_q <= '0;
            free_valid_q      <= 1'b0;
            free_preg_q       <= '0;
        end else begin
            valid_q           <= valid_d;
            done_q            <= done_d;
            head_q            <= head_d;
            tail_q            <= tail_d;
            count_q           <= count_d;
            commit_valid_q    <= commit_valid_d;
            commit_lreg_q     <= commit_lreg_d;
            commit_new_preg_q <= commit_new_preg_d;
            free_valid_q      <= free_valid_d;
            free_preg_q       <= free_preg_d;
        end
    end

    // Payload needs no reset: it is only read behind a set valid bit.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            mem_q[tail_q] <= '{uses_rw:   al.alloc_uses_rw,
                               lreg:      al.alloc_lreg,
                               new_preg:  al.alloc_new_preg,
                               prev_preg: al.alloc_prev_preg};
        end
    end

    assign al.alloc_ready     = !full;
    assign al.alloc_tag       = tail_q;
    assign al.commit_valid    = commit_valid_q;
    assign al.commit_lreg     = commit_lreg_q;
    assign al.commit_new_preg = commit_new_preg_q;
    assign al.free_valid      = free_valid_q;
    assign al.free_preg       = free_preg_q;
    assign al.count           = count_q;
    assign al.empty           = (count_q == '0);
    assign al.full            = full;
endmodule

// File: tb/tb_active_list.sv
// Directed bench for active_list: in-order retirement, out-of-order completion, full/wrap, store, flush, async reset.
module tb_active_list;
    localparam int DEPTH  = 32;
    localparam int PREG_W = 6;
    localparam int LREG_W = 5;
    localparam int TAG_W  = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    active_list_if #(.DEPTH(DEPTH), .PREG_W(PREG_W), .LREG_W(LREG_W), .TAG_W(TAG_W)) bus ();

    active_list #(.DEPTH(DEPTH), .PREG_W(PREG_W), .LREG_W(LREG_W), .TAG_W(TAG_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .al   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alloc_valid     = 1'b0;
        bus.alloc_uses_rw   = 1'b0;
        bus.alloc_lreg      = '0;
        bus.alloc_new_preg  = '0;
        bus.alloc_prev_preg = '0;
        bus.complete_valid  = 1'b0;
        bus.complete_tag    = '0;
        bus.flush           = 1'b0;
    endtask

    task automatic set_alloc(input logic rw, input int l, input int n, input int p);
        bus.alloc_valid     = 1'b1;
        bus.alloc_uses_rw   = rw;
        bus.alloc_lreg      = LREG_W'(l);
        bus.alloc_new_preg  = PREG_W'(n);
        bus.alloc_prev_preg = PREG_W'(p);
    endtask

    task automatic set_complete(input int t);
        bus.complete_valid = 1'b1;
        bus.complete_tag   = TAG_W'(t);
    endtask

    task automatic expect_commit(input string tag, input int l, input int n, input logic fv, input int fp);
        check_eq({tag, ".commit_valid"}, 32'(bus.commit_valid), 32'd1);
        check_eq({tag, ".commit_lreg"}, 32'(bus.commit_lreg), 32'(l));
        check_eq({tag, ".commit_new_preg"}, 32'(bus.commit_new_preg), 32'(n));
        check_eq({tag, ".free_valid"}, 32'(bus.free_valid), 32'(fv));
        check_eq({tag, ".free_preg"}, 32'(bus.free_preg), 32'(fp));
    endtask

    task automatic expect_idle(input string tag);
        check_eq({tag, ".commit_valid"}, 32'(bus.commit_valid), 32'd0);
        check_eq({tag, ".free_valid"}, 32'(bus.free_valid), 32'd0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst.count", 32'(bus.count), 32'd0);
        check_eq("rst.empty", 32'(bus.empty), 32'd1);
        check_eq("rst.full", 32'(bus.full), 32'd0);
        check_eq("rst.alloc_ready", 32'(bus.alloc_ready), 32'd1);
        check_eq("rst.alloc_tag", 32'(bus.alloc_tag), 32'd0);
        expect_idle("rst");
        check_eq("rst.commit_lreg", 32'(bus.commit_lreg), 32'd0);
        check_eq("rst.free_preg", 32'(bus.free_preg), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // In-order completion: commits on three consecutive cycles.
        for (int i = 0; i < 3; i++) begin
            set_alloc(1'b1, i + 1, 32 + i, i + 1);
            tick();
        end
        idle_inputs();
        check_eq("t1.count", 32'(bus.count), 32'd3);
        check_eq("t1.alloc_tag", 32'(bus.alloc_tag), 32'd3);
        check_eq("t1.empty", 32'(bus.empty), 32'd0);
        set_complete(0); tick();
        expect_idle("t1.lat");
        set_complete(1); tick();
        expect_commit("t1.c0", 1, 32, 1'b1, 1);
        set_complete(2); tick();
        expect_commit("t1.c1", 2, 33, 1'b1, 2);
        idle_inputs(); tick();
        expect_commit("t1.c2", 3, 34, 1'b1, 3);
        tick();
        expect_idle("t1.end");
        check_eq("t1.count_end", 32'(bus.count), 32'd0);
        check_eq("t1.empty_end", 32'(bus.empty), 32'd1);

        // Out-of-order completion: nothing retires until the head is done.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(1'b1, 4 + i, 40 + i, 10 + i);
            tick();
        end
        idle_inputs();
        set_complete(2); tick(); expect_idle("t2.a");
        set_complete(1); tick(); expect_idle("t2.b");
        idle_inputs();   tick(); expect_idle("t2.c");
        set_complete(0); tick(); expect_idle("t2.d");
        idle_inputs();   tick(); expect_commit("t2.c0", 4, 40, 1'b1, 10);
        tick(); expect_commit("t2.c1", 5, 41, 1'b1, 11);
        tick(); expect_commit("t2.c2", 6, 42, 1'b1, 12);
        tick(); expect_idle("t2.end");

        // Store (no register write) with a completion in its own allocation cycle, which is lost.
        set_alloc(1'b0, 7, 50, 20);
        set_complete(3);
        tick();
        idle_inputs();
        check_eq("t4.alloc_tag", 32'(bus.alloc_tag), 32'd4);
        tick(); expect_idle("t4.a");
        tick(); expect_idle("t4.b");
        set_complete(3); tick(); expect_idle("t4.c");
        idle_inputs();   tick(); expect_commit("t4.st", 7, 50, 1'b0, 20);
        tick();
        check_eq("t4.empty", 32'(bus.empty), 32'd1);

        // Fill to DEPTH, drop the overflow, then alloc and commit together after full clears.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(1'b1, i, i, i + 32);
            tick();
        end
        set_alloc(1'b1, 31, 63, 63);
        check_eq("t3.count_full", 32'(bus.count), 32'd32);
        check_eq("t3.full", 32'(bus.full), 32'd1);
        check_eq("t3.alloc_ready", 32'(bus.alloc_ready), 32'd0);
        check_eq("t3.alloc_tag_wrap", 32'(bus.alloc_tag), 32'd0);
        tick();
        idle_inputs();
        check_eq("t3.count_drop", 32'(bus.count), 32'd32);
        check_eq("t3.tag_drop", 32'(bus.alloc_tag), 32'd0);
        set_complete(0); tick();
        set_complete(1); tick();
        expect_commit("t3.c0", 0, 0, 1'b1, 32);
        check_eq("t3.count_31", 32'(bus.count), 32'd31);
        check_eq("t3.ready_back", 32'(bus.alloc_ready), 32'd1);
        idle_inputs();
        set_alloc(1'b1, 9, 60, 30);
        tick();
        idle_inputs();
        expect_commit("t3.c1", 1, 1, 1'b1, 33);
        check_eq("t3.count_same", 32'(bus.count), 32'd31);
        check_eq("t3.tag_after", 32'(bus.alloc_tag), 32'd1);
        for (int k = 2; k <= DEPTH; k++) begin
            set_complete(k % DEPTH);
            tick();
        end
        idle_inputs();
        tick();
        expect_commit("t3.wrap", 9, 60, 1'b1, 30);
        tick();
        check_eq("t3.count_end", 32'(bus.count), 32'd0);

        // Flush beats a same-cycle commit, alloc and complete.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_alloc(1'b1, i, 10 + i, 20 + i);
            tick();
        end
        idle_inputs();
        set_complete(1); tick(); expect_idle("t5.a");
        set_complete(0); tick(); expect_idle("t5.b");
        bus.flush = 1'b1;
        set_alloc(1'b1, 15, 15, 15);
        set_complete(2);
        tick();
        idle_inputs();
        expect_idle("t5.flush");
        check_eq("t5.count", 32'(bus.count), 32'd0);
        check_eq("t5.empty", 32'(bus.empty), 32'd1);
        check_eq("t5.alloc_tag", 32'(bus.alloc_tag), 32'd0);
        tick();
        expect_idle("t5.after");
        check_eq("t5.count2", 32'(bus.count), 32'd0);
        set_alloc(1'b1, 3, 3, 3);
        tick();
        idle_inputs();
        check_eq("t5.realloc_tag", 32'(bus.alloc_tag), 32'd1);
        check_eq("t5.realloc_cnt", 32'(bus.count), 32'd1);
        tick(); tick();
        expect_idle("t5.notdone");

        // Asynchronous reset between clock edges with entries pending and a commit pulse live.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_alloc(1'b1, i + 1, i + 1, i + 1);
            tick();
        end
        idle_inputs();
        check_eq("t6.count4", 32'(bus.count), 32'd4);
        set_complete(0); tick();
        idle_inputs();   tick();
        expect_commit("t6.c0", 1, 1, 1'b1, 1);
        #3 rst_n = 1'b0;
        #1;
        check_eq("t6.count", 32'(bus.count), 32'd0);
        check_eq("t6.empty", 32'(bus.empty), 32'd1);
        check_eq("t6.full", 32'(bus.full), 32'd0);
        check_eq("t6.alloc_ready", 32'(bus.alloc_ready), 32'd1);
        check_eq("t6.alloc_tag", 32'(bus.alloc_tag), 32'd0);
        expect_idle("t6.rst");
        check_eq("t6.commit_lreg", 32'(bus.commit_lreg), 32'd0);
        check_eq("t6.free_preg", 32'(bus.free_preg), 32'd0);
        #1 rst_n = 1'b1;
        set_alloc(1'b1, 2, 2, 2);
        tick();
        idle_inputs();
        check_eq("t6.next_tag", 32'(bus.alloc_tag), 32'd1);
        check_eq("t6.next_cnt", 32'(bus.count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
